regfile: RTL
============

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: ZERO_REG, default 31, index of the hardwired-zero register.
REQ-002 Port: clk  input  1  clock; all writes occur on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: rf_we  input  1  write enable from the write-back stage.
REQ-005 Port: rf_w_addr  input  5  write address.
REQ-006 Port: rf_w_data  input  32  write data.
REQ-007 Port: ra1  input  5  read port 1 address (Ra field).
REQ-008 Port: ra2  input  5  read port 2 address (Rb field, or Rc for stores, selected upstream).
REQ-009 Port: rd1  output  32  read port 1 data.
REQ-010 Port: rd2  output  32  read port 2 data.
REQ-011 Port: ra1_hit  output  1  rd1 is sourced from the in-flight write this cycle.
REQ-012 Port: ra2_hit  output  1  rd2 is sourced from the in-flight write this cycle.

Function
REQ-013 Storage SHALL be 31 32-bit registers, one per index 0..31 except ZERO_REG.
REQ-014 A write SHALL occur on the rising clk edge when rf_we=1, rst=0 and rf_w_addr!=ZERO_REG; the register at rf_w_addr takes rf_w_data.
REQ-015 A write with rf_w_addr==ZERO_REG SHALL be discarded with no state change.
REQ-016 rf_we=0 SHALL leave all registers unchanged regardless of rf_w_addr/rf_w_data, including X values.
REQ-017 Reads SHALL be combinational, with zero-cycle latency from ra1/ra2 to rd1/rd2.
REQ-018 A read of ZERO_REG SHALL return 32'h0 and its hit flag SHALL be 0, even during a write to ZERO_REG.
REQ-019 Both read ports SHALL be independent; ra1==ra2 SHALL return identical data on both ports.
REQ-020 A register written at edge N SHALL be visible on the read ports from just after edge N.
REQ-021 A read in the cycle of a write to the same address is resolved by the macro in REQ-027 and REQ-028.
REQ-022 Two simultaneous reads of the register being written SHALL both follow the same rule.

Reset
REQ-023 rst=1 SHALL clear all registers to 32'h0 immediately, independent of clk.
REQ-024 While rst=1: no writes; rd1/rd2 SHALL read 32'h0 for every address; ra1_hit=ra2_hit=0.
REQ-025 A write coincident with a clk edge during rst=1 SHALL be lost.
REQ-026 After rst deasserts, the first write SHALL take effect at the first rising edge with rf_we=1.

Configuration
REQ-027 With RF_BYPASS_EN defined: when rf_we=1, rst=0, rf_w_addr!=ZERO_REG and raX==rf_w_addr, rdX SHALL equal rf_w_data combinationally and raX_hit=1.
REQ-028 With RF_BYPASS_EN undefined: rdX SHALL return the stored (pre-write) value in that cycle and ra1_hit, ra2_hit SHALL be tied to 0.

Verification
REQ-029 Reset: assert rst asynchronously mid-cycle after writing R5=32'hDEADBEEF -> rd1 with ra1=5 reads 32'h0 immediately, before any clk edge.
REQ-030 Write/read: write R3=32'h12345678, then R7=32'hCAFEF00D -> ra1=3, ra2=7 give 32'h12345678 and 32'hCAFEF00D; same-cycle ra1=ra2=7 both give 32'hCAFEF00D.
REQ-031 Zero register: write R31=32'hFFFFFFFF with ra1=31 -> rd1=0 in the write cycle and afterwards, ra1_hit=0.
REQ-032 Same-cycle conflict: R9 holds 32'h1, write R9=32'h2 with ra1=ra2=9 -> with RF_BYPASS_EN rd1=rd2=32'h2 and hits=1; without it rd1=rd2=32'h1 and hits=0; both modes read 32'h2 next cycle.
REQ-033 Disabled write: rf_we=0, rf_w_addr=4, rf_w_data=32'hAAAA5555 -> R4 is unchanged and no hit flag asserts.
REQ-034 Randomized: 10k random writes and reads checked against a reference model with R31=0; run both macro settings.

Source files
------------

// File: rtl/regfile.sv
// regfile: 31 x 32-bit register file with a hardwired-zero entry at ZERO_REG.
// Two combinational read ports, one synchronous write port, async active-high
// reset. Optional write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile #(
    parameter int ZERO_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rf_we,
    input  logic [4:0]  rf_w_addr,
    input  logic [31:0] rf_w_data,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        ra1_hit,
    output logic        ra2_hit
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_act;

    // Writes to the zero register are dropped here so they never reach state.
    assign wr_act = rf_we && (rf_w_addr != ZR);

    // Next-state: only the addressed entry changes, and only on a live write.
    always_comb begin
        regs_d = regs_q;
        if (wr_act)
            regs_d[rf_w_addr] = rf_w_data;
    end

    // Storage; the ZERO_REG slot is held at zero and trims away in synthesis.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= (i == ZERO_REG) ? 32'h0 : regs_d[i];
        end
    end

`ifdef RF_BYPASS_EN
    // Forward the in-flight write data to a matching read port.
    always_comb begin
        ra1_hit = !rst && wr_act && (ra1 == rf_w_addr);
        ra2_hit = !rst && wr_act && (ra2 == rf_w_addr);
    end
`else
    // No forwarding: readers see the pre-write value during the write cycle.
    always_comb begin
        ra1_hit = 1'b0;
        ra2_hit = 1'b0;
    end
`endif

    // Read muxes; reset and the zero register both force zero.
    always_comb begin
        if (rst || ra1 == ZR) rd1 = 32'h0;
        else if (ra1_hit)     rd1 = rf_w_data;
        else                  rd1 = regs_q[ra1];
        if (rst || ra2 == ZR) rd2 = 32'h0;
        else if (ra2_hit)     rd2 = rf_w_data;
        else                  rd2 = regs_q[ra2];
    end

endmodule
